// File: rtl/mult_cell_pkg.sv
// Shared definitions for the multiplier-cell arbiter.
//   state_t      : arbiter FSM states
//   CELL_LAT_MAX : largest supported cell register latency
//   HALF_W       : width of one operand slice fed to the 16x16 partials
//   combine_lo() : folds the three partial products into the low product word
package mult_cell_pkg;

  typedef enum logic [1:0] {IDLE, RUN, COMBINE, RESP} state_t;

  localparam int CELL_LAT_MAX = 4;
  localparam int HALF_W       = 16;

  // Only the low half of the cross partials can reach bits [31:16] of the
  // product, so their upper halves are dropped before the shift.
  function automatic logic [31:0] combine_lo(input logic [31:0] p1,
                                             input logic [31:0] p2,
                                             input logic [31:0] p3);
    logic [HALF_W-1:0] mid;
    mid = p2[HALF_W-1:0] + p3[HALF_W-1:0];
    return p1 + {mid, {HALF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/mult_cell_rr_arb.sv
// Two-way round-robin grant.
//   clk, reset : clock, asynchronous active-high reset
//   req0, req1 : requests
//   en         : arbitration allowed this cycle (grants forced low otherwise)
//   grant0/1   : combinational grants; a grant also updates last_grant
// last_grant resets to 1 so requester 0 wins the first contested cycle.
module mult_cell_rr_arb (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic en,
  output logic grant0,
  output logic grant1
);

  logic last_grant;

  assign grant0 = en & req0 & (~req1 | last_grant);
  assign grant1 = en & req1 & (~req0 | ~last_grant);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (grant0) begin
      last_grant <= 1'b0;
    end else if (grant1) begin
      last_grant <= 1'b1;
    end
  end

endmodule

// File: rtl/mult_cell_arbiter.sv
// Shares one 3-partial-product multiplier cell between two requesters.
// A granted request's operands are latched and held on cell_src*, cell_en is
// raised for CELL_LAT cycles, the partials are combined into the low 32-bit
// product, and the owner receives a one-cycle resp*_valid pulse.
//   clk, reset            : clock, asynchronous active-high reset
//   reqN_valid/ready      : request handshake (ready only in IDLE)
//   reqN_src1/src2        : operands
//   respN_valid           : one-cycle result pulse for requester N
//   resp_result           : low product word, held until the next combine
//   cell_src1/src2/en     : cell operands and register enable
//   cell_p1/p2/p3         : partial products returned by the cell
// Optional build macro MULT_CELL_ARBITER_PERF_CNT_EN adds saturating
// grant0_cnt, grant1_cnt and contend_cnt outputs.
module mult_cell_arbiter
  import mult_cell_pkg::*;
#(
  parameter int CELL_LAT = 1,
  parameter int DATA_W   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_src1,
  input  logic [31:0] req0_src2,
  output logic        resp0_valid,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_src1,
  input  logic [31:0] req1_src2,
  output logic        resp1_valid,
  output logic [31:0] resp_result,
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  output logic        cell_en,
  input  logic [31:0] cell_p1,
  input  logic [31:0] cell_p2,
  input  logic [31:0] cell_p3
`ifdef MULT_CELL_ARBITER_PERF_CNT_EN
  ,
  output logic [15:0] grant0_cnt,
  output logic [15:0] grant1_cnt,
  output logic [15:0] contend_cnt
`endif
);

  if (DATA_W != 32) begin : g_bad_width
    $error("mult_cell_arbiter: DATA_W must be 32");
  end
  if (CELL_LAT < 1 || CELL_LAT > CELL_LAT_MAX) begin : g_bad_lat
    $error("mult_cell_arbiter: CELL_LAT out of range 1..4");
  end

  localparam logic [2:0] LAT_LAST = 3'(CELL_LAT - 1);

  state_t      state, state_nxt;
  logic [2:0]  lat_cnt;
  logic        owner;
  logic        idle;
  logic        hs;
  logic        unused_hi;

  // The cross partials contribute only their low halves.
  assign unused_hi = ^{cell_p2[31:16], cell_p3[31:16]};

  assign idle = (state == IDLE);
  assign hs   = req0_ready | req1_ready;

  mult_cell_rr_arb u_arb (
    .clk    (clk),
    .reset  (reset),
    .req0   (req0_valid),
    .req1   (req1_valid),
    .en     (idle),
    .grant0 (req0_ready),
    .grant1 (req1_ready)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cell_en     = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    case (state)
      IDLE:    if (hs) state_nxt = RUN;
      RUN: begin
        cell_en = 1'b1;
        if (lat_cnt == LAT_LAST) state_nxt = COMBINE;
      end
      COMBINE: state_nxt = RESP;
      RESP: begin
        resp0_valid = ~owner;
        resp1_valid = owner;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake: capture operands / owner; RUN: count cell cycles;
  // COMBINE: register the folded product.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cell_src1   <= '0;
      cell_src2   <= '0;
      owner       <= 1'b0;
      lat_cnt     <= '0;
      resp_result <= '0;
    end else begin
      if (hs) begin
        cell_src1 <= req1_ready ? req1_src1 : req0_src1;
        cell_src2 <= req1_ready ? req1_src2 : req0_src2;
        owner     <= req1_ready;
        lat_cnt   <= '0;
      end
      if (state == RUN) begin
        lat_cnt <= lat_cnt + 3'd1;
      end
      if (state == COMBINE) begin
        resp_result <= combine_lo(cell_p1, cell_p2, cell_p3);
      end
    end
  end

`ifdef MULT_CELL_ARBITER_PERF_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant0_cnt  <= '0;
      grant1_cnt  <= '0;
      contend_cnt <= '0;
    end else begin
      if (req0_ready) grant0_cnt <= sat_inc(grant0_cnt);
      if (req1_ready) grant1_cnt <= sat_inc(grant1_cnt);
      if (idle && req0_valid && req1_valid) contend_cnt <= sat_inc(contend_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_mult_cell_arbiter.sv
module tb_mult_cell_arbiter;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, resp0_valid;
  logic        req1_valid, req1_ready, resp1_valid;
  logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
  logic [31:0] resp_result, cell_src1, cell_src2;
  logic        cell_en;
  logic [31:0] cell_p1, cell_p2, cell_p3;
`ifdef MULT_CELL_ARBITER_PERF_CNT_EN
  logic [15:0] grant0_cnt, grant1_cnt, contend_cnt;
  logic [15:0] g0_m, g1_m, ct_m;
`endif

  always #5 clk = ~clk;

  mult_cell_arbiter #(.CELL_LAT(LAT), .DATA_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_src1   (req0_src1),
    .req0_src2   (req0_src2),
    .resp0_valid (resp0_valid),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_src1   (req1_src1),
    .req1_src2   (req1_src2),
    .resp1_valid (resp1_valid),
    .resp_result (resp_result),
    .cell_src1   (cell_src1),
    .cell_src2   (cell_src2),
    .cell_en     (cell_en),
    .cell_p1     (cell_p1),
    .cell_p2     (cell_p2),
    .cell_p3     (cell_p3)
`ifdef MULT_CELL_ARBITER_PERF_CNT_EN
    ,
    .grant0_cnt  (grant0_cnt),
    .grant1_cnt  (grant1_cnt),
    .contend_cnt (contend_cnt)
`endif
  );

  // Behavioural cell: LAT register stages, all shifting while cell_en is high.
  logic [31:0] s1 [LAT];
  logic [31:0] s2 [LAT];
  logic [31:0] s3 [LAT];
  always @(posedge clk) begin
    if (cell_en) begin
      s1[0] <= 32'(cell_src1[15:0]) * 32'(cell_src2[15:0]);
      s2[0] <= 32'(cell_src1[15:0]) * 32'(cell_src2[31:16]);
      s3[0] <= 32'(cell_src1[31:16]) * 32'(cell_src2[15:0]);
      for (int i = 1; i < LAT; i++) begin
        s1[i] <= s1[i-1];
        s2[i] <= s2[i-1];
        s3[i] <= s3[i-1];
      end
    end
  end
  assign cell_p1 = s1[LAT-1];
  assign cell_p2 = s2[LAT-1];
  assign cell_p3 = s3[LAT-1];

  typedef struct {
    logic        own;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          t0;
  } item_t;

  item_t       q[$];
  int          glog[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          resp_cnt = 0;
  logic        lg_m = 1'b1;
  logic [31:0] last_res = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    logic idle_m;
    int   d;
    if (reset) begin
      chk("rst_rdy",  {req0_ready, req1_ready}, 2'b00);
      chk("rst_resp", {resp0_valid, resp1_valid}, 2'b00);
      chk("rst_en",   cell_en, 1'b0);
      chk("rst_src",  cell_src1 | cell_src2, 32'h0);
      chk("rst_res",  resp_result, 32'h0);
      q.delete();
      lg_m     = 1'b1;
      last_res = '0;
`ifdef MULT_CELL_ARBITER_PERF_CNT_EN
      g0_m = '0; g1_m = '0; ct_m = '0;
`endif
    end else begin
      idle_m = (q.size() == 0);
      chk("rdy0", req0_ready, idle_m & req0_valid & (~req1_valid | lg_m));
      chk("rdy1", req1_ready, idle_m & req1_valid & (~req0_valid | ~lg_m));
`ifdef MULT_CELL_ARBITER_PERF_CNT_EN
      chk("g0_cnt", grant0_cnt, g0_m);
      chk("g1_cnt", grant1_cnt, g1_m);
      chk("ct_cnt", contend_cnt, ct_m);
      if (idle_m && req0_valid && req1_valid && ct_m != 16'hFFFF) ct_m = ct_m + 1;
`endif
      if (idle_m) begin
        chk("idle_en", cell_en, 1'b0);
        chk("hold", resp_result, last_res);
        if (resp0_valid | resp1_valid) chk("spurious", {resp0_valid, resp1_valid}, 2'b00);
      end else begin
        d = cyc - q[0].t0;
        chk("en", cell_en, (d >= 1 && d <= LAT));
        if (cell_en) begin
          chk("src1_hold", cell_src1, q[0].a);
          chk("src2_hold", cell_src2, q[0].b);
        end
        chk("resp_when", resp0_valid | resp1_valid, d == LAT + 2);
        if (resp0_valid | resp1_valid) begin
          resp_cnt++;
          chk("resp_own", {resp1_valid, resp0_valid}, q[0].own ? 2'b10 : 2'b01);
          chk("result", resp_result, q[0].res);
          last_res = resp_result;
        end
        if (d >= LAT + 2) void'(q.pop_front());
      end
      if (req0_valid && req0_ready) begin
        q.push_back('{1'b0, req0_src1, req0_src2, req0_src1 * req0_src2, cyc});
        glog.push_back(0);
        lg_m = 1'b0;
`ifdef MULT_CELL_ARBITER_PERF_CNT_EN
        if (g0_m != 16'hFFFF) g0_m = g0_m + 1;
`endif
      end
      if (req1_valid && req1_ready) begin
        q.push_back('{1'b1, req1_src1, req1_src2, req1_src1 * req1_src2, cyc});
        glog.push_back(1);
        lg_m = 1'b1;
`ifdef MULT_CELL_ARBITER_PERF_CNT_EN
        if (g1_m != 16'hFFFF) g1_m = g1_m + 1;
`endif
      end
    end
  end

  task automatic wait_grants(input int target);
    int n = 0;
    while (glog.size() < target && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    chk("grant_to", glog.size() >= target, 1'b1);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (q.size() != 0 && n < 100);
    chk("idle_to", q.size() == 0, 1'b1);
  endtask

  task automatic send(input int idx, input logic [31:0] a, input logic [31:0] b);
    int start;
    start = glog.size();
    @(posedge clk); #1;
    if (idx == 0) begin
      req0_valid = 1'b1; req0_src1 = a; req0_src2 = b;
    end else begin
      req1_valid = 1'b1; req1_src1 = a; req1_src2 = b;
    end
    wait_grants(start + 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    int start;
    int rc;
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_src1 = '0; req0_src2 = '0; req1_src1 = '0; req1_src2 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    send(0, 32'h0001_2345, 32'h0000_0010);
    chk("single", last_res, 32'h0012_3450);
    send(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("wrap_ones", last_res, 32'h0000_0001);
    send(0, 32'h0001_0000, 32'h0001_0000);
    chk("wrap_zero", last_res, 32'h0000_0000);
    for (int i = 0; i < 4; i++) send(i % 2, $urandom, $urandom);

    // Contention: both valids held, operands changing while unaccepted.
    start = glog.size();
    @(posedge clk); #1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int n = 0; n < 100 && glog.size() < start + 4; n++) begin
      req0_src1 = $urandom; req0_src2 = $urandom;
      req1_src1 = $urandom; req1_src2 = $urandom;
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("cont_cnt", glog.size(), start + 4);
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      if (glog.size() > start + i) chk("alt", glog[start + i], i % 2);
    end

    // Reset one cycle after the handshake drops the operation.
    start = glog.size();
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_src1 = 32'h1234; req0_src2 = 32'h5678;
    wait_grants(start + 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    reset = 1'b1;
    rc = resp_cnt;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (8) @(posedge clk);
    #1 chk("rst_drop", resp_cnt, rc);
    start = glog.size();
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_grants(start + 1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (glog.size() > start) chk("rst_first", glog[start], 0);
    wait_idle();

`ifdef MULT_CELL_ARBITER_PERF_CNT_EN
    send(0, 32'd7, 32'd9);
    send(0, 32'd3, 32'd5);
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
